// File: rtl/four_bank_pkg.sv
// Shared constants for the four-bank main-memory timing model.
// Address layout: [0] byte-in-word, [2:1] bank select, [ADDR_W-1:3] row.
package four_bank_pkg;
    localparam int BANK_BITS = 2;
    localparam int NUM_BANKS = 1 << BANK_BITS;
    localparam int BANK_BUSY = 4;
    localparam int RD_LAT    = 2;
    localparam int BANK_LSB  = 1;
    localparam int ROW_LSB   = BANK_LSB + BANK_BITS;
endpackage

// File: rtl/mem_bank.sv
// One word-interleaved bank: storage array, occupancy down-counter and the
// stage-1 read register. The caller asserts sel only for accepted requests.
module mem_bank #(
    parameter int DATA_W    = 16,
    parameter int IDX_W     = 13,
    parameter int BANK_BUSY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic [IDX_W-1:0]  row,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);
    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = $clog2(BANK_BUSY);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [CNT_W-1:0]  cnt;

    // Array and read word carry no reset so the storage can map onto block RAM.
    always_ff @(posedge clk) begin
        if (sel && we) begin
            mem[row] <= wdata;
        end
        if (sel && !we) begin
            rdata <= mem[row];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rvalid <= 1'b0;
            cnt    <= '0;
        end else begin
            rvalid <= sel && !we;
            if (sel) begin
                cnt <= CNT_W'(BANK_BUSY - 1);
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign busy = (cnt != '0);
endmodule

// File: rtl/four_bank_mem.sv
// Banked main-memory timing model: four interleaved banks, fixed two-cycle
// read latency, collisions flagged on err rather than queued.
module four_bank_mem #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int BANK_DEPTH = 8192,
    parameter int RD_LAT     = four_bank_pkg::RD_LAT,
    parameter int BANK_BUSY  = four_bank_pkg::BANK_BUSY
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    input  logic              wr,
    input  logic              rd,
    output logic [DATA_W-1:0] DataOut,
    output logic              rd_valid,
    output logic [3:0]        busy,
    output logic              stall,
    output logic              err
);
    import four_bank_pkg::*;

    localparam int IDX_W = $clog2(BANK_DEPTH);

    logic                 req;
    logic                 accept;
    logic [BANK_BITS-1:0] bank;
    logic [IDX_W-1:0]     row;
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];
    logic [NUM_BANKS-1:0] bank_rvalid;
    logic [DATA_W-1:0]    s1_data;
    logic [DATA_W-1:0]    s2_data;
    logic                 s2_valid;

    assign bank   = Addr[ROW_LSB-1:BANK_LSB];
    assign row    = Addr[ROW_LSB +: IDX_W];
    assign req    = rd | wr;
    assign stall  = req & busy[bank];
    assign err    = req & ((rd & wr) | Addr[0] | busy[bank]);
    assign accept = req & ~err;

    for (genvar i = 0; i < NUM_BANKS; i++) begin : g_bank
        mem_bank #(
            .DATA_W   (DATA_W),
            .IDX_W    (IDX_W),
            .BANK_BUSY(BANK_BUSY)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .sel   (accept && (bank == BANK_BITS'(i))),
            .we    (wr),
            .row   (row),
            .wdata (DataIn),
            .busy  (busy[i]),
            .rdata (bank_rdata[i]),
            .rvalid(bank_rvalid[i])
        );
    end

    // At most one bank holds a valid stage-1 word, since only one request is accepted per cycle.
    always_comb begin
        s1_data = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_rvalid[i]) begin
                s1_data = bank_rdata[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else begin
            s2_valid <= |bank_rvalid;
            s2_data  <= s1_data;
        end
    end

    // Only the two-stage pipeline exists; other latencies never raise rd_valid.
    assign rd_valid = s2_valid & (RD_LAT == 2);
    assign DataOut  = rd_valid ? s2_data : '0;
endmodule

// File: tb/tb_four_bank_mem.sv
// Scoreboard bench for four_bank_mem: a cycle-indexed bank model decides acceptance,
// and a negedge monitor matches every rd_valid against the expected-read queue.
module tb_four_bank_mem;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] Addr = '0;
    logic [15:0] DataIn = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] DataOut;
    logic        rd_valid;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    typedef struct {
        logic [15:0] data;
        int          due;
    } exp_t;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    exp_t        sb[$];
    logic [15:0] mem_model [int];
    int          free_at [4];
    logic [15:0] pool [16];

    four_bank_mem dut (
        .clk     (clk),
        .rst     (rst),
        .Addr    (Addr),
        .DataIn  (DataIn),
        .wr      (wr),
        .rd      (rd),
        .DataOut (DataOut),
        .rd_valid(rd_valid),
        .busy    (busy),
        .stall   (stall),
        .err     (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: a read result is due in exactly one cycle; every other cycle must be quiet.
    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].due == cyc) begin
            checkOutput("rd_valid", 32'(rd_valid), 32'd1);
            checkOutput("DataOut", 32'(DataOut), 32'(sb[0].data));
            void'(sb.pop_front());
        end else begin
            checkOutput("rd_valid_idle", 32'(rd_valid), 32'd0);
            checkOutput("DataOut_idle", 32'(DataOut), 32'd0);
        end
    end

    // Called at posedge+1; drives one cycle's request and checks the combinational flags.
    task automatic applyStimulus(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
        int          cur;
        int          b;
        logic [3:0]  bexp;
        logic        req;
        logic        e;
        logic        s;
        rd = r; wr = w; Addr = a; DataIn = d;
        cur = cyc;
        for (int i = 0; i < 4; i++) bexp[i] = (cur < free_at[i]);
        b   = int'(a[2:1]);
        req = r | w;
        s   = req && bexp[b];
        e   = req && ((r && w) || a[0] || bexp[b]);
        @(negedge clk);
        checkOutput("busy", 32'(busy), 32'(bexp));
        checkOutput("stall", 32'(stall), 32'(s));
        checkOutput("err", 32'(err), 32'(e));
        if (req && !e) begin
            free_at[b] = cur + 4;
            if (w) mem_model[int'(a >> 1)] = d;
            else   sb.push_back('{mem_model[int'(a >> 1)], cur + 2});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic resetDut(input int n);
        rst = 1'b0; rd = 1'b0; wr = 1'b0;
        sb.delete();
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        @(negedge clk);
        checkOutput("busy_in_reset", 32'(busy), 32'd0);
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) free_at[i] = 0;
        #1;
        resetDut(2);
        idle(2);

        applyStimulus(1'b0, 1'b1, 16'h0008, 16'hBEEF);
        idle(3);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        idle(4);

        applyStimulus(1'b0, 1'b1, 16'h1230, 16'h0A0A);
        applyStimulus(1'b0, 1'b1, 16'h1232, 16'h0B0B);
        applyStimulus(1'b0, 1'b1, 16'h1234, 16'h0C0C);
        applyStimulus(1'b0, 1'b1, 16'h1236, 16'h0D0D);
        idle(3);
        applyStimulus(1'b1, 1'b0, 16'h1230, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h1232, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h1234, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h1236, 16'h0000);
        idle(4);

        applyStimulus(1'b0, 1'b1, 16'h0010, 16'h1111);
        idle(3);
        applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0000);
        applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000);
        idle(4);

        applyStimulus(1'b0, 1'b1, 16'h0020, 16'h2222);
        idle(3);
        applyStimulus(1'b1, 1'b1, 16'h0020, 16'hDEAD);
        idle(3);
        applyStimulus(1'b1, 1'b0, 16'h0020, 16'h0000);
        idle(4);
        applyStimulus(1'b1, 1'b0, 16'h0005, 16'h0000);
        idle(4);

        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        resetDut(1);
        applyStimulus(1'b1, 1'b0, 16'h0008, 16'h0000);
        idle(4);

        for (int i = 0; i < 16; i++) begin
            pool[i] = 16'($urandom) & 16'hFFFE;
            applyStimulus(1'b0, 1'b1, pool[i], 16'($urandom));
            idle(3);
        end
        for (int n = 0; n < 400; n++) begin
            int          k;
            logic [15:0] a;
            k = int'($urandom_range(0, 99));
            a = pool[$urandom_range(0, 15)];
            if ($urandom_range(0, 15) == 0) a[0] = 1'b1;
            if (k < 45)      applyStimulus(1'b1, 1'b0, a, 16'h0000);
            else if (k < 80) applyStimulus(1'b0, 1'b1, a, 16'($urandom));
            else if (k < 85) applyStimulus(1'b1, 1'b1, a, 16'($urandom));
            else             idle(1);
        end
        idle(5);
        checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
